// File: rtl/score_pkg.sv
// Shared types and sizing for the score-to-BCD converter.
// Optional feature macro used by the top: VBLANK_LATCH_EN.
package score_pkg;

    localparam int unsigned BIN_W      = 17;
    localparam int unsigned NUM_DIGITS = 5;
    localparam int unsigned DIG_W      = 4 * NUM_DIGITS;
    localparam int unsigned CNT_W      = $clog2(BIN_W + 1);

    // Largest value that fits in NUM_DIGITS decimal digits.
    localparam logic [BIN_W-1:0] MAX_VAL = BIN_W'((10 ** NUM_DIGITS) - 1);

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

endpackage

// File: rtl/score_bcd_conv_if.sv
// Handshake and result bus between the game-logic score counter and the BCD converter.
interface score_bcd_conv_if;

    logic                           start;
    logic [score_pkg::BIN_W-1:0]    score_bin;
    logic                           vblank_pulse;
    logic                           busy;
    logic                           done;
    logic                           overflow;
    logic [score_pkg::DIG_W-1:0]    digits_o;

    modport master (
        output start, score_bin, vblank_pulse,
        input  busy, done, overflow, digits_o
    );

    modport slave (
        input  start, score_bin, vblank_pulse,
        output busy, done, overflow, digits_o
    );

endinterface

// File: rtl/bcd_add3.sv
// Double-dabble correction cell: digits of 5 or more get +3 before the shift.
module bcd_add3
    import score_pkg::*;
(
    input  bcd_digit_t digit,
    output bcd_digit_t corrected
);

    assign corrected = (digit >= 4'd5) ? (digit + 4'd3) : digit;

endmodule

// File: rtl/score_bcd_conv.sv
// Sequential binary-to-BCD score converter (double dabble, one bit per clock).
// Define VBLANK_LATCH_EN to defer display updates to the next vertical blank.
module score_bcd_conv
    import score_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    score_bcd_conv_if.slave    bus
);

    state_t                         state, state_nxt;
    logic [CNT_W-1:0]               cnt, cnt_nxt;
    logic [BIN_W-1:0]               bin_sr, bin_nxt;
    bcd_digit_t [NUM_DIGITS-1:0]    bcd, bcd_nxt, bcd_adj;
    logic                           busy_q, busy_nxt;
    logic                           done_q, done_nxt;
    logic                           ovf_q, ovf_nxt;
    logic [DIG_W-1:0]               digits_q;

    // All digits corrected in parallel ahead of each shift.
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .digit     (bcd[g]),
            .corrected (bcd_adj[g])
        );
    end

    // State register and working datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            bin_sr <= '0;
            bcd    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            bin_sr <= bin_nxt;
            bcd    <= bcd_nxt;
            busy_q <= busy_nxt;
            done_q <= done_nxt;
            ovf_q  <= ovf_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        bin_nxt   = bin_sr;
        bcd_nxt   = bcd;
        busy_nxt  = busy_q;
        done_nxt  = 1'b0;
        ovf_nxt   = ovf_q;

        case (state)
            IDLE: begin
                busy_nxt = 1'b0;
                if (bus.start) begin
                    if (bus.score_bin > MAX_VAL) begin
                        bin_nxt = MAX_VAL;
                        ovf_nxt = 1'b1;
                    end else begin
                        bin_nxt = bus.score_bin;
                        ovf_nxt = 1'b0;
                    end
                    bcd_nxt   = '0;
                    cnt_nxt   = CNT_W'(BIN_W);
                    busy_nxt  = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy_nxt = 1'b1;
                if (cnt != '0) begin
                    {bcd_nxt, bin_nxt} = {bcd_adj, bin_sr} << 1;
                    cnt_nxt            = cnt - CNT_W'(1);
                end else begin
                    done_nxt  = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            default: begin
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

`ifdef VBLANK_LATCH_EN
    logic [DIG_W-1:0] pending_q;
    logic             pending_vld;

    // Latest finished result waits in pending until the next vertical blank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q   <= '0;
            pending_vld <= 1'b0;
            digits_q    <= '0;
        end else begin
            if (bus.vblank_pulse && pending_vld) begin
                digits_q <= pending_q;
            end
            if (state == DONE) begin
                pending_q   <= bcd;
                pending_vld <= 1'b1;
            end else if (bus.vblank_pulse) begin
                pending_vld <= 1'b0;
            end
        end
    end
`else
    logic unused_vblank;
    assign unused_vblank = bus.vblank_pulse;

    // Final BCD lands on the display on the edge that enters DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_q <= '0;
        end else if (state == SHIFT && cnt == '0) begin
            digits_q <= bcd;
        end
    end
`endif

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.overflow = ovf_q;
    assign bus.digits_o = digits_q;

endmodule

// File: tb/tb_score_bcd_conv.sv
// Directed bench for score_bcd_conv with a scoreboard of expected conversions.
module tb_score_bcd_conv;
    import score_pkg::*;

    localparam int unsigned LATENCY = BIN_W + 1;
    localparam int unsigned LIMIT   = 40;

    typedef struct {
        logic [DIG_W-1:0] digits;
        logic             ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    logic [DIG_W-1:0] shown;

    always #5 clk = ~clk;

    score_bcd_conv_if bus ();

    score_bcd_conv dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    function automatic logic [DIG_W-1:0] to_bcd(input int unsigned v);
        logic [DIG_W-1:0] r;
        int unsigned      x;
        r = '0;
        x = v;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one start request; the accepting edge is edge 0.
    task automatic start_conv(input int unsigned s);
        exp_t e;
        int unsigned max_v;
        max_v = (10 ** NUM_DIGITS) - 1;
        e.ovf    = (s > max_v);
        e.digits = to_bcd(e.ovf ? max_v : s);
        sb.push_back(e);
        @(negedge clk);
        bus.score_bin = BIN_W'(s);
        bus.start     = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("busy_after_accept", 32'(bus.busy), 32'd1);
    endtask

    // Wait for done (bounded), compare against scoreboard, then settle the display.
    task automatic finish_conv(input int already, input int vb_delay);
        int   lat;
        exp_t e;
        lat = already;
        while (lat < int'(LIMIT)) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.done) break;
        end
        check("done_seen", 32'(bus.done), 32'd1);
        check("latency", 32'(lat), 32'(LATENCY));
        e = sb.pop_front();
        check("overflow", 32'(bus.overflow), 32'(e.ovf));
        check("busy_at_done", 32'(bus.busy), 32'd1);
`ifdef VBLANK_LATCH_EN
        check("digits_held_at_done", 32'(bus.digits_o), 32'(shown));
`else
        check("digits_at_done", 32'(bus.digits_o), 32'(e.digits));
        shown = e.digits;
`endif
        @(posedge clk);
        #1;
        check("done_one_cycle", 32'(bus.done), 32'd0);
        check("busy_after_done", 32'(bus.busy), 32'd0);
        repeat (vb_delay) @(posedge clk);
        #1;
        check("digits_stable", 32'(bus.digits_o), 32'(shown));
`ifdef VBLANK_LATCH_EN
        @(negedge clk);
        bus.vblank_pulse = 1'b1;
        @(posedge clk);
        #1;
        bus.vblank_pulse = 1'b0;
        shown = e.digits;
        check("digits_after_vblank", 32'(bus.digits_o), 32'(shown));
`endif
    endtask

    task automatic expect_no_done(input int cycles, input string tag);
        int seen;
        seen = 0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            if (bus.done) seen++;
        end
        check(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        rst_n            = 1'b0;
        bus.start        = 1'b0;
        bus.score_bin    = '0;
        bus.vblank_pulse = 1'b0;
        shown            = '0;
        #12;
        check("rst_digits", 32'(bus.digits_o), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_overflow", 32'(bus.overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        start_conv(0);       finish_conv(0, 2);
        start_conv(12345);   finish_conv(0, 2);
        start_conv(99999);   finish_conv(0, 2);
        start_conv(131071);  finish_conv(0, 2);
        start_conv(7);       finish_conv(0, 2);

        // Second start during SHIFT must be dropped, not queued.
        start_conv(500);
        repeat (4) @(posedge clk);
        @(negedge clk);
        bus.score_bin = BIN_W'(600);
        bus.start     = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        finish_conv(5, 2);
        expect_no_done(30, "no_second_done");
        check("busy_idle_after_ignored", 32'(bus.busy), 32'd0);
        check("digits_500_kept", 32'(bus.digits_o), 32'(shown));

        // Asynchronous reset in the middle of a conversion.
        start_conv(54321);
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        void'(sb.pop_front());
        shown = '0;
        check("midrst_digits", 32'(bus.digits_o), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        check("midrst_overflow", 32'(bus.overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        expect_no_done(25, "no_done_after_reset");
        start_conv(54321);   finish_conv(0, 2);

        // Display must wait for vblank when latching is enabled.
        start_conv(42);      finish_conv(0, 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
